// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the pipeline
// MEM stage (port P) and a secondary loader/debug port (port S). Each access
// is latched at grant, held stable for MEM_LATENCY memory cycles, and then
// completed in a one-cycle DONE state. Ties are broken round-robin.
module dmem_arbiter #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              p_read,
    input  logic              p_write,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic [DATA_W-1:0] p_rdata,
    output logic              p_stall,
    input  logic              s_req,
    input  logic              s_we,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_wdata,
    output logic [DATA_W-1:0] s_rdata,
    output logic              s_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_P = 1'b0,
        OWNER_S = 1'b1
    } owner_t;

    state_t            state;
    owner_t            owner;
    owner_t            last_owner;
    logic              op_write;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt;
    logic              mem_read_q;
    logic              mem_write_q;
    logic              s_ack_q;
    logic [DATA_W-1:0] p_rdata_q;
    logic [DATA_W-1:0] s_rdata_q;

    logic              p_pending;
    logic              grant_s;

    // S wins when it is the only requester, or on a tie when P was served last
    assign p_pending = p_read | p_write;
    assign grant_s   = s_req & (~p_pending | (last_owner == OWNER_P));

    // Sequencer: grant and latch in IDLE, count out the access in BUSY, retire in DONE
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            owner       <= OWNER_P;
            last_owner  <= OWNER_S;
            op_write    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt         <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            s_ack_q     <= 1'b0;
            p_rdata_q   <= '0;
            s_rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (p_pending | s_req) begin
                        state <= BUSY;
                        cnt   <= CNT_LOAD;
                        if (grant_s) begin
                            owner       <= OWNER_S;
                            op_write    <= s_we;
                            addr_q      <= s_addr;
                            wdata_q     <= s_wdata;
                            mem_read_q  <= ~s_we;
                            mem_write_q <= s_we;
                        end else begin
                            owner       <= OWNER_P;
                            op_write    <= p_write;
                            addr_q      <= p_addr;
                            wdata_q     <= p_wdata;
                            mem_read_q  <= ~p_write;
                            mem_write_q <= p_write;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state       <= DONE;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        s_ack_q     <= (owner == OWNER_S);
                        if (!op_write) begin
                            if (owner == OWNER_P) begin
                                p_rdata_q <= mem_data_out;
                            end else begin
                                s_rdata_q <= mem_data_out;
                            end
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    s_ack_q    <= 1'b0;
                    last_owner <= owner;
                end
                default: begin
                    state       <= IDLE;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    s_ack_q     <= 1'b0;
                end
            endcase
        end
    end

    // The pipeline is released only in the DONE cycle of its own access
    assign p_stall = p_pending & ~((state == DONE) & (owner == OWNER_P));

    assign mem_addr    = addr_q;
    assign mem_data_in = wdata_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign s_ack       = s_ack_q;
    assign p_rdata     = p_rdata_q;
    assign s_rdata     = s_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios followed by randomized traffic on both
// ports, all compared every cycle against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int L  = 2;

    logic          CLK = 1'b0;
    logic          RST;
    logic          p_read, p_write;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata, p_rdata;
    logic          p_stall;
    logic          s_req, s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;
    logic          s_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in, mem_data_out;
    logic          mem_read, mem_write;

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LATENCY(L)) dut (
        .CLK(CLK), .RST(RST),
        .p_read(p_read), .p_write(p_write), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_stall(p_stall),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ack(s_ack),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_read(mem_read), .mem_write(mem_write), .mem_data_out(mem_data_out)
    );

    always #5 CLK = ~CLK;

    // Memory environment: read data is only valid in the last cycle of a
    // MEM_LATENCY-long read strobe, garbage otherwise
    logic [DW-1:0] mem [0:255];
    int            rd_run;

    always @(posedge CLK or posedge RST) begin
        if (RST) rd_run <= 0;
        else if (mem_read) rd_run <= rd_run + 1;
        else rd_run <= 0;
    end

    assign mem_data_out = (mem_read && rd_run == L - 1) ? mem[mem_addr[7:0]] : 32'hBAD0_BAD0;

    // Reference model: one outstanding transaction, described by its age in cycles since grant
    logic [DW-1:0] ref_mem [0:255];
    bit            m_active;
    int            m_age;
    bit            m_owner;
    bit            m_last;
    bit            m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] exp_prdata, exp_srdata;

    bit            mdoneP, mdoneS;
    logic          seen_stall, seen_sack, seen_mread, seen_mwrite;
    logic [DW-1:0] seen_prdata;

    int checks = 0;
    int errors = 0;

    task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic modelReset();
        m_active   = 1'b0;
        m_age      = 0;
        m_last     = 1'b1;
        exp_prdata = '0;
        exp_srdata = '0;
    endtask

    task automatic checkOutput();
        bit preq, busy, done;
        preq = p_read | p_write;
        busy = m_active && m_age >= 1 && m_age <= L;
        done = m_active && m_age == L + 1;
        mdoneP = done && !m_owner;
        mdoneS = done && m_owner;
        checkValue("mem_read", 64'(mem_read), 64'(busy && !m_write));
        checkValue("mem_write", 64'(mem_write), 64'(busy && m_write));
        if (busy) checkValue("mem_addr", 64'(mem_addr), 64'(m_addr));
        if (busy && m_write) checkValue("mem_data_in", 64'(mem_data_in), 64'(m_wdata));
        checkValue("p_stall", 64'(p_stall), 64'(preq && !mdoneP));
        checkValue("s_ack", 64'(s_ack), 64'(mdoneS));
        checkValue("p_rdata", 64'(p_rdata), 64'(exp_prdata));
        checkValue("s_rdata", 64'(s_rdata), 64'(exp_srdata));
        seen_stall  = p_stall;
        seen_sack   = s_ack;
        seen_mread  = mem_read;
        seen_mwrite = mem_write;
        seen_prdata = p_rdata;
    endtask

    task automatic modelAdvance();
        bit preq;
        preq = p_read | p_write;
        if (m_active) begin
            if (m_age == L && !m_write) begin
                if (!m_owner) exp_prdata = ref_mem[m_addr[7:0]];
                else exp_srdata = ref_mem[m_addr[7:0]];
            end
            if (m_age == L + 1) begin
                m_active = 1'b0;
                m_last   = m_owner;
                if (m_write) ref_mem[m_addr[7:0]] = m_wdata;
            end else begin
                m_age++;
            end
        end else if (preq || s_req) begin
            if (preq && s_req) m_owner = !m_last;
            else m_owner = !preq;
            if (!m_owner) begin
                m_write = p_write;
                m_addr  = p_addr;
                m_wdata = p_wdata;
            end else begin
                m_write = s_we;
                m_addr  = s_addr;
                m_wdata = s_wdata;
            end
            m_active = 1'b1;
            m_age    = 1;
        end
    endtask

    // One clock cycle: compare, clock the environment memory, advance the model
    task automatic stepCycle();
        bit            wr_en;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        #1;
        checkOutput();
        wr_en = mem_write;
        wa    = mem_addr;
        wd    = mem_data_in;
        @(posedge CLK);
        #1;
        if (wr_en) mem[wa[7:0]] = wd;
        modelAdvance();
        @(negedge CLK);
    endtask

    task automatic applyStimulus(input logic pr, input logic pw, input logic [AW-1:0] pa,
                                 input logic [DW-1:0] pd, input logic sr, input logic sw,
                                 input logic [AW-1:0] sa, input logic [DW-1:0] sd);
        p_read  = pr;
        p_write = pw;
        p_addr  = pa;
        p_wdata = pd;
        s_req   = sr;
        s_we    = sw;
        s_addr  = sa;
        s_wdata = sd;
    endtask

    initial begin
        int n, nr, nw, na;
        int order [$];

        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[8'h10]     = 32'hDEAD_BEEF;
        ref_mem[8'h10] = 32'hDEAD_BEEF;

        // Reset values
        RST = 1'b1;
        applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
        modelReset();
        #2;
        checkValue("rst_p_rdata", 64'(p_rdata), 64'h0);
        checkValue("rst_s_rdata", 64'(s_rdata), 64'h0);
        checkValue("rst_s_ack", 64'(s_ack), 64'h0);
        checkValue("rst_mem_addr", 64'(mem_addr), 64'h0);
        checkValue("rst_mem_data_in", 64'(mem_data_in), 64'h0);
        checkValue("rst_mem_read", 64'(mem_read), 64'h0);
        checkValue("rst_mem_write", 64'(mem_write), 64'h0);
        @(negedge CLK);
        RST = 1'b0;
        stepCycle();

        // P-only read of 0x10
        applyStimulus(1, 0, 32'h10, '0, 0, 0, '0, '0);
        n = 0; nr = 0;
        for (int c = 0; c < 20; c++) begin
            stepCycle();
            nr += int'(seen_mread);
            if (!seen_stall) break;
            n++;
        end
        checkValue("p_read_stall_cycles", 64'(n), 64'd3);
        checkValue("p_read_mread_cycles", 64'(nr), 64'd2);
        checkValue("p_read_data", 64'(seen_prdata), 64'hDEAD_BEEF);
        applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
        stepCycle();

        // S write 0xCAFE to 0x20, then read it back
        applyStimulus(0, 0, '0, '0, 1, 1, 32'h20, 32'h0000_CAFE);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            stepCycle();
            if (seen_sack) break;
            n++;
        end
        checkValue("s_write_ack_latency", 64'(n), 64'd3);
        s_req = 1'b0;
        na = 0;
        for (int c = 0; c < 4; c++) begin
            stepCycle();
            na += int'(seen_sack);
        end
        checkValue("s_write_no_extra_ack", 64'(na), 64'd0);
        applyStimulus(0, 0, '0, '0, 1, 0, 32'h20, '0);
        for (int c = 0; c < 20; c++) begin
            stepCycle();
            if (seen_sack) break;
        end
        s_req = 1'b0;
        #1;
        checkValue("s_read_data", 64'(s_rdata), 64'h0000_CAFE);
        checkValue("s_read_p_rdata_kept", 64'(p_rdata), 64'hDEAD_BEEF);
        stepCycle();

        // Simultaneous held requests from reset: P, S, P
        RST = 1'b1;
        modelReset();
        @(negedge CLK);
        RST = 1'b0;
        applyStimulus(1, 0, 32'h10, '0, 1, 0, 32'h20, '0);
        for (int c = 0; c < 40 && order.size() < 3; c++) begin
            stepCycle();
            if (seen_sack) order.push_back(1);
            if (!seen_stall) order.push_back(0);
        end
        checkValue("tie_completions", 64'(order.size()), 64'd3);
        if (order.size() >= 3) begin
            checkValue("tie_first_P", 64'(order[0]), 64'd0);
            checkValue("tie_second_S", 64'(order[1]), 64'd1);
            checkValue("tie_third_P", 64'(order[2]), 64'd0);
        end
        applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
        stepCycle();

        // s_req dropped in the second BUSY cycle still completes
        applyStimulus(0, 0, '0, '0, 1, 0, 32'h10, '0);
        nr = 0; na = 0;
        stepCycle();
        stepCycle();
        nr += int'(seen_mread);
        s_req = 1'b0;
        for (int c = 0; c < 6; c++) begin
            stepCycle();
            nr += int'(seen_mread);
            na += int'(seen_sack);
        end
        checkValue("s_drop_mread_cycles", 64'(nr), 64'd2);
        checkValue("s_drop_ack_count", 64'(na), 64'd1);
        checkValue("s_drop_data", 64'(s_rdata), 64'hDEAD_BEEF);

        // Reset in the middle of an S write
        applyStimulus(0, 0, '0, '0, 1, 1, 32'h40, 32'h0000_1234);
        stepCycle();
        stepCycle();
        #2;
        RST = 1'b1;
        #1;
        checkValue("rst_mid_mem_write", 64'(mem_write), 64'h0);
        checkValue("rst_mid_mem_read", 64'(mem_read), 64'h0);
        modelReset();
        s_req = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        stepCycle();
        checkValue("rst_mid_p_rdata", 64'(p_rdata), 64'h0);
        checkValue("rst_mid_s_ack", 64'(s_ack), 64'h0);

        // p_read and p_write together act as a write, then read back
        applyStimulus(1, 1, 32'h30, 32'h5, 0, 0, '0, '0);
        nr = 0; nw = 0;
        for (int c = 0; c < 20; c++) begin
            stepCycle();
            nr += int'(seen_mread);
            nw += int'(seen_mwrite);
            if (!seen_stall) break;
        end
        checkValue("both_mwrite_cycles", 64'(nw), 64'd2);
        checkValue("both_mread_cycles", 64'(nr), 64'd0);
        p_write = 1'b0;
        for (int c = 0; c < 20; c++) begin
            stepCycle();
            if (!seen_stall) break;
        end
        checkValue("both_readback", 64'(seen_prdata), 64'h5);
        applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
        stepCycle();

        // Randomized traffic on both ports
        for (int c = 0; c < 600; c++) begin
            if (!(p_read | p_write) && $urandom_range(0, 2) == 0) begin
                int op;
                op      = int'($urandom_range(0, 3));
                p_read  = (op != 2);
                p_write = (op >= 2);
                p_addr  = 32'($urandom_range(0, 15) * 4);
                p_wdata = $urandom;
            end
            if (!s_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    s_req   = 1'b1;
                    s_we    = 1'($urandom_range(0, 1));
                    s_addr  = 32'($urandom_range(0, 15) * 4);
                    s_wdata = $urandom;
                end
            end else if (m_active && m_owner && $urandom_range(0, 7) == 0) begin
                s_req = 1'b0;
            end
            stepCycle();
            if (mdoneP) begin
                p_read  = 1'b0;
                p_write = 1'b0;
            end
            if (mdoneS) s_req = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
